// File: rtl/integrate_dump_if.sv
// Sample/dump bus for integrate_dump.
//   master: wipe-off front end and loop side (drives samples, epoch, out_ready)
//   slave : integrate_dump (drives the dumped sums and status flags)
// Signals:
//   in_valid, epoch           sample strobe and code-epoch strobe
//   in_{e,p,l}_{i,q}          signed wiped-off samples, IN_W bits
//   out_{e,p,l}_{i,q}         signed dumped sums, OUT_W bits
//   out_count                 samples in the dumped period, CNT_W bits
//   out_valid / out_ready     dump handshake
//   timeout                   dump was forced by the length limit
//   overrun                   sticky: an unaccepted dump was overwritten
interface integrate_dump_if #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned CNT_W = 16
) ();
    logic                    in_valid;
    logic                    epoch;
    logic signed [IN_W-1:0]  in_e_i;
    logic signed [IN_W-1:0]  in_e_q;
    logic signed [IN_W-1:0]  in_p_i;
    logic signed [IN_W-1:0]  in_p_q;
    logic signed [IN_W-1:0]  in_l_i;
    logic signed [IN_W-1:0]  in_l_q;
    logic signed [OUT_W-1:0] out_e_i;
    logic signed [OUT_W-1:0] out_e_q;
    logic signed [OUT_W-1:0] out_p_i;
    logic signed [OUT_W-1:0] out_p_q;
    logic signed [OUT_W-1:0] out_l_i;
    logic signed [OUT_W-1:0] out_l_q;
    logic [CNT_W-1:0]        out_count;
    logic                    out_valid;
    logic                    out_ready;
    logic                    timeout;
    logic                    overrun;

    modport master (
        output in_valid, epoch,
        output in_e_i, in_e_q, in_p_i, in_p_q, in_l_i, in_l_q,
        output out_ready,
        input  out_e_i, out_e_q, out_p_i, out_p_q, out_l_i, out_l_q,
        input  out_count, out_valid, timeout, overrun
    );

    modport slave (
        input  in_valid, epoch,
        input  in_e_i, in_e_q, in_p_i, in_p_q, in_l_i, in_l_q,
        input  out_ready,
        output out_e_i, out_e_q, out_p_i, out_p_q, out_l_i, out_l_q,
        output out_count, out_valid, timeout, overrun
    );
endinterface

// File: rtl/integrate_dump.sv
// Integrate-and-dump of the six E/P/L I/Q wipe-off streams over one C/A code
// period, delimited by the PRN generator's code-epoch strobe. Each period's
// sums are shifted, saturated and presented to the loops on a valid/ready
// dump register. A period reaching MAX_LEN samples without an epoch is dumped
// with timeout set.
// Ports:
//   clk   system clock
//   rst   asynchronous active-low reset
//   bus   integrate_dump_if slave modport (samples in, dumps out)
module integrate_dump #(
    parameter int unsigned IN_W    = 32,
    parameter int unsigned ACC_W   = 48,
    parameter int unsigned OUT_W   = 32,
    parameter int unsigned SHIFT   = 0,
    parameter int unsigned MAX_LEN = 4096,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    integrate_dump_if.slave   bus
);

    localparam int unsigned NCH = 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_LEN);

    typedef enum logic [0:0] {
        SYNC,
        INTEG
    } state_t;

    state_t state_q, state_d;

    logic signed [IN_W-1:0]  in_s       [NCH];
    logic signed [ACC_W-1:0] in_ext     [NCH];
    logic signed [ACC_W-1:0] seed_acc   [NCH];
    logic signed [ACC_W-1:0] sum_c      [NCH];
    logic signed [ACC_W-1:0] acc_q      [NCH];
    logic signed [ACC_W-1:0] acc_d      [NCH];
    logic signed [ACC_W-1:0] dump_acc_c [NCH];
    logic signed [OUT_W-1:0] out_q      [NCH];

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] seed_cnt;
    logic [CNT_W-1:0] dump_cnt_c;
    logic             dump_c;
    logic             dump_to_c;

    logic [CNT_W-1:0] out_count_q;
    logic             out_valid_q;
    logic             timeout_q;
    logic             overrun_q;

    // Arithmetic shift, then clamp to the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        logic [ACC_W-OUT_W:0]    top;
        s   = v >>> SHIFT;
        top = s[ACC_W-1:OUT_W-1];
        if ((&top) || ~(|top)) begin
            sat_out = s[OUT_W-1:0];
        end else if (s[ACC_W-1]) begin
            sat_out = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_out = {1'b0, {(OUT_W-1){1'b1}}};
        end
    endfunction

    assign in_s[0] = bus.in_e_i;
    assign in_s[1] = bus.in_e_q;
    assign in_s[2] = bus.in_p_i;
    assign in_s[3] = bus.in_p_q;
    assign in_s[4] = bus.in_l_i;
    assign in_s[5] = bus.in_l_q;

    // Sign-extended samples, running sums and the value a new period starts from.
    always_comb begin : datapath_comb
        for (int k = 0; k < NCH; k++) begin
            in_ext[k]   = {{(ACC_W-IN_W){in_s[k][IN_W-1]}}, in_s[k]};
            sum_c[k]    = acc_q[k] + in_ext[k];
            seed_acc[k] = bus.in_valid ? in_ext[k] : '0;
        end
    end

    assign seed_cnt = bus.in_valid ? CNT_W'(1) : '0;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin : fsm_reg
        if (!rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, next accumulator/counter and dump request.
    always_comb begin : fsm_comb
        state_d    = state_q;
        cnt_d      = cnt_q;
        dump_c     = 1'b0;
        dump_to_c  = 1'b0;
        dump_cnt_c = cnt_q;
        for (int k = 0; k < NCH; k++) begin
            acc_d[k]      = acc_q[k];
            dump_acc_c[k] = acc_q[k];
        end

        case (state_q)
            SYNC: begin
                // First epoch only aligns the period; nothing to dump yet.
                if (bus.epoch) begin
                    state_d = INTEG;
                    cnt_d   = seed_cnt;
                    for (int k = 0; k < NCH; k++) begin
                        acc_d[k] = seed_acc[k];
                    end
                end
            end
            INTEG: begin
                if (bus.epoch) begin
                    // The epoch-cycle sample is chip 0 of the next period.
                    dump_c = 1'b1;
                    cnt_d  = seed_cnt;
                    for (int k = 0; k < NCH; k++) begin
                        acc_d[k] = seed_acc[k];
                    end
                end else if (bus.in_valid) begin
                    if (cnt_q == CNT_LAST) begin
                        // Missing epoch: this sample completes a forced period.
                        dump_c     = 1'b1;
                        dump_to_c  = 1'b1;
                        dump_cnt_c = CNT_FULL;
                        cnt_d      = '0;
                        for (int k = 0; k < NCH; k++) begin
                            dump_acc_c[k] = sum_c[k];
                            acc_d[k]      = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        for (int k = 0; k < NCH; k++) begin
                            acc_d[k] = sum_c[k];
                        end
                    end
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // Accumulators and sample counter.
    always_ff @(posedge clk or negedge rst) begin : acc_reg
        if (!rst) begin
            cnt_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int k = 0; k < NCH; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    // Dump register with valid/ready handshake; a new dump always wins.
    always_ff @(posedge clk or negedge rst) begin : dump_reg
        if (!rst) begin
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                out_q[k] <= '0;
            end
        end else if (dump_c) begin
            out_count_q <= dump_cnt_c;
            out_valid_q <= 1'b1;
            timeout_q   <= dump_to_c;
            for (int k = 0; k < NCH; k++) begin
                out_q[k] <= sat_out(dump_acc_c[k]);
            end
            // Pending dump lost without being accepted.
            if (out_valid_q && !bus.out_ready) begin
                overrun_q <= 1'b1;
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_e_i   = out_q[0];
    assign bus.out_e_q   = out_q[1];
    assign bus.out_p_i   = out_q[2];
    assign bus.out_p_q   = out_q[3];
    assign bus.out_l_i   = out_q[4];
    assign bus.out_l_q   = out_q[5];
    assign bus.out_count = out_count_q;
    assign bus.out_valid = out_valid_q;
    assign bus.timeout   = timeout_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_integrate_dump.sv
// Directed bench for integrate_dump: a period table on a full-width instance,
// hand sequences for timeout, overrun, reset and a narrow saturating instance.
module tb_integrate_dump;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    integrate_dump_if #(.IN_W(32), .OUT_W(32), .CNT_W(16)) bus1 ();
    integrate_dump_if #(.IN_W(16), .OUT_W(16), .CNT_W(16)) bus2 ();

    integrate_dump #(
        .IN_W(32), .ACC_W(48), .OUT_W(32), .SHIFT(0), .MAX_LEN(4096), .CNT_W(16)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    integrate_dump #(
        .IN_W(16), .ACC_W(32), .OUT_W(16), .SHIFT(4), .MAX_LEN(4096), .CNT_W(16)
    ) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        bit ev;       // epoch cycle opening the period carries a sample
        int base;     // sample value (channel k gets base*(k+1) when ramp)
        bit alt;      // alternate +base / -base
        bit ramp;
        bit gaps;     // idle cycle before every third body sample
        int n;        // samples after the epoch cycle
        int exp_cnt;
        int exp_sum;  // expected sum for channel 0
    } vec_t;

    vec_t tbl [7];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input bit v, input bit ep, input int val, input bit ramp);
        bus1.in_valid = v;
        bus1.epoch    = ep;
        bus1.in_e_i   = ramp ? val * 1 : val;
        bus1.in_e_q   = ramp ? val * 2 : val;
        bus1.in_p_i   = ramp ? val * 3 : val;
        bus1.in_p_q   = ramp ? val * 4 : val;
        bus1.in_l_i   = ramp ? val * 5 : val;
        bus1.in_l_q   = ramp ? val * 6 : val;
    endtask

    task automatic drive2(input bit v, input bit ep, input int val);
        bus2.in_valid = v;
        bus2.epoch    = ep;
        bus2.in_e_i   = 16'(val);
        bus2.in_e_q   = 16'(val);
        bus2.in_p_i   = 16'(val);
        bus2.in_p_q   = 16'(val);
        bus2.in_l_i   = 16'(val);
        bus2.in_l_q   = 16'(val);
    endtask

    function automatic longint out1(input int k);
        case (k)
            0: return longint'(bus1.out_e_i);
            1: return longint'(bus1.out_e_q);
            2: return longint'(bus1.out_p_i);
            3: return longint'(bus1.out_p_q);
            4: return longint'(bus1.out_l_i);
            default: return longint'(bus1.out_l_q);
        endcase
    endfunction

    function automatic longint out2(input int k);
        case (k)
            0: return longint'(bus2.out_e_i);
            1: return longint'(bus2.out_e_q);
            2: return longint'(bus2.out_p_i);
            3: return longint'(bus2.out_p_q);
            4: return longint'(bus2.out_l_i);
            default: return longint'(bus2.out_l_q);
        endcase
    endfunction

    task automatic check_dump1(input string name, input bit ramp, input longint sum,
                               input int cnt, input bit to);
        check({name, " valid"}, longint'(bus1.out_valid), 1);
        check({name, " count"}, longint'(bus1.out_count), longint'(cnt));
        check({name, " timeout"}, longint'(bus1.timeout), longint'(to));
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s ch%0d", name, k), out1(k), ramp ? sum * (k + 1) : sum);
        end
    endtask

    task automatic check_dump2(input string name, input longint val, input int cnt);
        check({name, " valid"}, longint'(bus2.out_valid), 1);
        check({name, " count"}, longint'(bus2.out_count), longint'(cnt));
        check({name, " timeout"}, longint'(bus2.timeout), 0);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s ch%0d", name, k), out2(k), val);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        vec_t r;
        int   idx;
        int   val;

        tbl[0] = '{1'b0, 3,        1'b0, 1'b0, 1'b0, 1023, 1023, 3069};
        tbl[1] = '{1'b1, 5,        1'b1, 1'b1, 1'b0, 1021, 1022, 0};
        tbl[2] = '{1'b1, 7,        1'b0, 1'b0, 1'b0, 0,    1,    7};
        tbl[3] = '{1'b0, 0,        1'b0, 1'b0, 1'b0, 0,    0,    0};
        tbl[4] = '{1'b1, -2,       1'b0, 1'b1, 1'b1, 9,    10,   -20};
        tbl[5] = '{1'b1, -1000000, 1'b0, 1'b1, 1'b0, 3,    4,    -4000000};
        tbl[6] = '{1'b0, 1,        1'b0, 1'b0, 1'b0, 4095, 4095, 4095};

        rst = 1'b0;
        drive1(0, 0, 0, 0);
        drive2(0, 0, 0);
        bus1.out_ready = 1'b1;
        bus2.out_ready = 1'b1;
        #12;
        check("reset valid", longint'(bus1.out_valid), 0);
        check("reset count", longint'(bus1.out_count), 0);
        check("reset p_i", out1(2), 0);
        check("reset overrun", longint'(bus1.overrun), 0);
        @(negedge clk);
        rst = 1'b1;

        // Period table: each epoch cycle dumps the previous record.
        for (int i = 0; i < 7; i++) begin
            r = tbl[i];
            drive1(1'b1 & r.ev, 1'b1, r.ev ? r.base : 55, r.ramp);
            tick();
            if (i == 0) check("sync epoch no dump", longint'(bus1.out_valid), 0);
            else check_dump1($sformatf("vec%0d", i - 1), tbl[i-1].ramp,
                             longint'(tbl[i-1].exp_sum), tbl[i-1].exp_cnt, 1'b0);
            idx = r.ev ? 1 : 0;
            for (int j = 0; j < r.n; j++) begin
                if (r.gaps && (j % 3 == 2)) begin
                    drive1(0, 0, 99, r.ramp);
                    tick();
                end
                val = (r.alt && (idx % 2 == 1)) ? -r.base : r.base;
                drive1(1, 0, val, r.ramp);
                tick();
                idx++;
                if (j == 0 && i > 0)
                    check($sformatf("vec%0d accepted", i - 1), longint'(bus1.out_valid), 0);
            end
        end
        drive1(0, 1, 55, 0);
        tick();
        check_dump1("vec6", 1'b0, 4095, 4095, 1'b0);

        // Forced dump at MAX_LEN, then restart from zero.
        for (int j = 0; j < 4096; j++) begin
            drive1(1, 0, 1, 0);
            if (j == 4095) check("no early dump", longint'(bus1.out_valid), 0);
            tick();
        end
        check_dump1("timeout dump", 1'b0, 4096, 4096, 1'b1);
        for (int j = 0; j < 2; j++) begin
            drive1(1, 0, 1, 0);
            tick();
        end
        drive1(0, 1, 0, 0);
        tick();
        check_dump1("after timeout", 1'b0, 2, 2, 1'b0);

        // Handshake: accept+dump in one cycle, then overwrite without accept.
        drive1(0, 0, 0, 0);
        tick();
        check("hs idle valid", longint'(bus1.out_valid), 0);
        check("hs idle overrun", longint'(bus1.overrun), 0);
        bus1.out_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            drive1(1, 0, 4, 0);
            tick();
        end
        drive1(0, 1, 0, 0);
        tick();
        check_dump1("dump A", 1'b0, 8, 2, 1'b0);
        drive1(1, 0, 9, 0);
        tick();
        check("A held", out1(2), 8);
        bus1.out_ready = 1'b1;
        drive1(0, 1, 0, 0);
        tick();
        check_dump1("dump B", 1'b0, 9, 1, 1'b0);
        check("accept+dump no overrun", longint'(bus1.overrun), 0);
        bus1.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive1(1, 0, 1, 0);
            tick();
        end
        drive1(0, 1, 0, 0);
        tick();
        check_dump1("dump C", 1'b0, 3, 3, 1'b0);
        check("overrun set", longint'(bus1.overrun), 1);
        drive1(0, 0, 0, 0);
        tick();
        tick();
        check("C held valid", longint'(bus1.out_valid), 1);
        check("C held l_q", out1(5), 3);
        check("overrun sticky", longint'(bus1.overrun), 1);
        bus1.out_ready = 1'b1;
        tick();
        check("C accepted", longint'(bus1.out_valid), 0);
        check("overrun after accept", longint'(bus1.overrun), 1);

        // Reset mid-period discards everything and resynchronises.
        bus1.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive1(1, 0, 1, 0);
            tick();
        end
        drive1(0, 1, 0, 0);
        tick();
        check("pre-reset p_i", out1(2), 3);
        for (int j = 0; j < 500; j++) begin
            drive1(1, 0, 2, 0);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        check("rst valid", longint'(bus1.out_valid), 0);
        check("rst p_i", out1(2), 0);
        check("rst count", longint'(bus1.out_count), 0);
        check("rst overrun", longint'(bus1.overrun), 0);
        @(negedge clk);
        rst = 1'b1;
        bus1.out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            drive1(1, 0, 5, 0);
            tick();
        end
        check("sync ignores samples", longint'(bus1.out_valid), 0);
        drive1(1, 1, 2, 0);
        tick();
        check("resync no dump", longint'(bus1.out_valid), 0);
        for (int j = 0; j < 3; j++) begin
            drive1(1, 0, 2, 0);
            tick();
        end
        check("no dump before 2nd epoch", longint'(bus1.out_valid), 0);
        drive1(0, 1, 55, 0);
        tick();
        check_dump1("post-reset dump", 1'b0, 8, 4, 1'b0);
        drive1(0, 0, 0, 0);

        // Narrow instance: SHIFT=4, OUT_W=16 saturation and rounding.
        drive2(0, 1, 0);
        tick();
        check("sat sync no dump", longint'(bus2.out_valid), 0);
        for (int j = 0; j < 1023; j++) begin
            drive2(1, 0, 32767);
            tick();
        end
        drive2(1, 1, -32768);
        tick();
        check_dump2("sat pos", 32767, 1023);
        for (int j = 0; j < 1022; j++) begin
            drive2(1, 0, -32768);
            tick();
        end
        drive2(0, 1, 0);
        tick();
        check_dump2("sat neg", -32768, 1023);
        for (int j = 0; j < 3; j++) begin
            drive2(1, 0, 16);
            tick();
        end
        drive2(0, 1, 0);
        tick();
        check_dump2("shift pos", 3, 3);
        drive2(1, 0, -40);
        tick();
        drive2(0, 1, 0);
        tick();
        check_dump2("shift neg floor", -3, 1);
        drive2(0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
